// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter unit.
package perf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } perfState_t;

  localparam int unsigned CNT_CYCLES = 0;
  localparam int unsigned CNT_ISSUED = 1;
  localparam int unsigned CNT_SQUASH = 2;
  localparam int unsigned CNT_EVT0   = 3;

  localparam int unsigned INC_W  = 2;
  localparam int unsigned IDLE_W = 5;
  localparam int unsigned SEL_W  = 4;

  // Wide enough for the +2 squash case when both flushes fire together.
  typedef logic [INC_W-1:0] incAmt_t;

  function automatic incAmt_t flushInc(input logic flushA, input logic flushB);
    return incAmt_t'(flushA) + incAmt_t'(flushB);
  endfunction

endpackage

// File: rtl/perf_cnt.sv
// Single event counter with synchronous clear, 0..3 increment, wrap or
// saturate on overflow, and a sticky overflow flag.
module perf_cnt
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  incAmt_t          inc,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  localparam int unsigned SUM_W = CNT_W + 1;

  logic [SUM_W-1:0] sum;

  // Extra top bit of the sum is the carry out that marks an overflow.
  always_comb begin
    sum = {1'b0, count} + SUM_W'(inc);
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (inc != '0) begin
      if (sum[CNT_W]) begin
        ovf   <= 1'b1;
        count <= SATURATE ? '1 : sum[CNT_W-1:0];
      end else begin
        count <= sum[CNT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/perf_counter_unit.sv
// Performance monitor: counts cycles, issued/squashed instructions and generic
// events while running, and stops on a stable-PC zero-fetch halt window.
module perf_counter_unit
  import perf_pkg::*;
#(
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned NUM_EVT  = 4,
  parameter int unsigned HALT_LEN = 5,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic [31:0]                  instr_i,
  input  logic [31:0]                  pc_i,
  input  logic                         stallf_i,
  input  logic                         flushd_i,
  input  logic                         flushe_i,
  input  logic [NUM_EVT-1:0]           evt_i,
  input  logic [SEL_W-1:0]             rd_sel_i,
  output logic [CNT_W-1:0]             rd_data_o,
  output logic                         running_o,
  output logic                         halted_o,
  output logic                         done_o,
  output logic [CNT_EVT0+NUM_EVT-1:0]  ovf_o
);

  localparam int unsigned NUM_CNT = CNT_EVT0 + NUM_EVT;

  perfState_t        state;
  perfState_t        nextState;
  logic              runningNext;
  logic              haltedNext;
  logic              doneNext;

  logic [IDLE_W-1:0] idleCnt;
  logic [31:0]       prevPc;
  logic              idleHit;
  logic              haltHit;
  logic              countEn;

  incAmt_t           incAmt [NUM_CNT];
  logic [CNT_W-1:0]  cntVal [NUM_CNT];
  logic [NUM_CNT-1:0] cntOvf;
  logic [CNT_W-1:0]  rdNext;

  assign idleHit = (instr_i == 32'd0) && (pc_i == prevPc);
  assign haltHit = idleHit && (idleCnt == IDLE_W'(HALT_LEN - 1));
  assign countEn = (state == RUN) && !clear_i;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next state and registered-output next values; clear overrides everything.
  always_comb begin
    nextState   = state;
    runningNext = 1'b0;
    haltedNext  = 1'b0;
    doneNext    = 1'b0;
    case (state)
      IDLE:    if (enable_i) nextState = RUN;
      RUN:     if (haltHit) nextState = HALTED;
      HALTED:  nextState = HALTED;
      default: nextState = IDLE;
    endcase
    if (clear_i) begin
      nextState = IDLE;
    end
    runningNext = (nextState == RUN);
    haltedNext  = (nextState == HALTED);
    doneNext    = (state == RUN) && (nextState == HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      running_o <= 1'b0;
      halted_o  <= 1'b0;
      done_o    <= 1'b0;
      rd_data_o <= '0;
    end else begin
      running_o <= runningNext;
      halted_o  <= haltedNext;
      done_o    <= doneNext;
      rd_data_o <= clear_i ? '0 : rdNext;
    end
  end

  // Idle-fetch window: only tracked while running, any break restarts it.
  always_ff @(posedge clk) begin
    if (reset) begin
      prevPc  <= '0;
      idleCnt <= '0;
    end else begin
      prevPc <= pc_i;
      if (countEn && idleHit) begin
        idleCnt <= idleCnt + IDLE_W'(1);
      end else begin
        idleCnt <= '0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_CNT; k++) begin
      incAmt[k] = '0;
    end
    if (countEn) begin
      incAmt[CNT_CYCLES] = incAmt_t'(1);
      incAmt[CNT_ISSUED] = incAmt_t'((instr_i != 32'd0) && !stallf_i);
      incAmt[CNT_SQUASH] = flushInc(flushd_i, flushe_i);
      for (int k = 0; k < NUM_EVT; k++) begin
        incAmt[CNT_EVT0+k] = incAmt_t'(evt_i[k]);
      end
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : gCnt
    perf_cnt #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) uCnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear_i),
      .inc   (incAmt[g]),
      .count (cntVal[g]),
      .ovf   (cntOvf[g])
    );
  end

  assign ovf_o = cntOvf;

  // Unmapped selects read as zero.
  always_comb begin
    rdNext = '0;
    for (int k = 0; k < NUM_CNT; k++) begin
      if (rd_sel_i == SEL_W'(k)) begin
        rdNext = cntVal[k];
      end
    end
  end

endmodule

// File: tb/tb_perf_counter_unit.sv
// Bench for perf_counter_unit: a default 32-bit instance plus 8-bit wrap and
// saturate instances sharing one stimulus stream.
module tb_perf_counter_unit;

  localparam int unsigned NEVT = 4;
  localparam int unsigned NCNT = 3 + NEVT;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  logic clk;
  logic reset;
  logic enable;
  logic clear;
  logic [31:0] instr;
  logic [31:0] pc;
  logic stallf;
  logic flushd;
  logic flushe;
  logic [NEVT-1:0] evt;
  logic [3:0] rdSel;

  logic [31:0] rdA;
  logic [7:0] rdW;
  logic [7:0] rdS;
  logic runA, haltA, doneA;
  logic runW, haltW, doneW;
  logic runS, haltS, doneS;
  logic [NCNT-1:0] ovfA;
  logic [NCNT-1:0] ovfW;
  logic [NCNT-1:0] ovfS;

  int nChecks = 0;
  int nFail = 0;

  typedef struct {
    string name;
    logic enable;
    logic clear;
    logic [31:0] instr;
    logic pcHold;
    logic stallf;
    logic flushd;
    logic flushe;
    logic [3:0] evt;
    logic [3:0] rdSel;
    logic [31:0] expRd;
    logic expRun;
    logic expHalt;
    logic expDone;
  } vec_t;

  typedef struct {
    string name;
    logic [31:0] rd;
    logic run;
    logic halt;
    logic done;
  } exp_t;

  vec_t vecs[$];
  exp_t sbq[$];

  perf_counter_unit #(.CNT_W(32), .NUM_EVT(NEVT), .HALT_LEN(5), .SATURATE(1'b0)) dutA (
    .clk(clk), .reset(reset), .enable_i(enable), .clear_i(clear), .instr_i(instr),
    .pc_i(pc), .stallf_i(stallf), .flushd_i(flushd), .flushe_i(flushe), .evt_i(evt),
    .rd_sel_i(rdSel), .rd_data_o(rdA), .running_o(runA), .halted_o(haltA),
    .done_o(doneA), .ovf_o(ovfA)
  );

  perf_counter_unit #(.CNT_W(8), .NUM_EVT(NEVT), .HALT_LEN(5), .SATURATE(1'b0)) dutW (
    .clk(clk), .reset(reset), .enable_i(enable), .clear_i(clear), .instr_i(instr),
    .pc_i(pc), .stallf_i(stallf), .flushd_i(flushd), .flushe_i(flushe), .evt_i(evt),
    .rd_sel_i(rdSel), .rd_data_o(rdW), .running_o(runW), .halted_o(haltW),
    .done_o(doneW), .ovf_o(ovfW)
  );

  perf_counter_unit #(.CNT_W(8), .NUM_EVT(NEVT), .HALT_LEN(5), .SATURATE(1'b1)) dutS (
    .clk(clk), .reset(reset), .enable_i(enable), .clear_i(clear), .instr_i(instr),
    .pc_i(pc), .stallf_i(stallf), .flushd_i(flushd), .flushe_i(flushe), .evt_i(evt),
    .rd_sel_i(rdSel), .rd_data_o(rdS), .running_o(runS), .halted_o(haltS),
    .done_o(doneS), .ovf_o(ovfS)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input logic en, input logic clr,
                              input logic [31:0] ins, input logic hold, input logic st,
                              input logic fd, input logic fe, input logic [3:0] ev,
                              input logic [3:0] sel, input logic [31:0] rd,
                              input logic r, input logic h, input logic d);
    vec_t v;
    v.name = n; v.enable = en; v.clear = clr; v.instr = ins; v.pcHold = hold;
    v.stallf = st; v.flushd = fd; v.flushe = fe; v.evt = ev; v.rdSel = sel;
    v.expRd = rd; v.expRun = r; v.expHalt = h; v.expDone = d;
    return v;
  endfunction

  // Drive one table row, queue its expectation, then compare after the edge.
  task automatic runVec(input vec_t v);
    exp_t e;
    exp_t got;
    enable = v.enable;
    clear  = v.clear;
    instr  = v.instr;
    stallf = v.stallf;
    flushd = v.flushd;
    flushe = v.flushe;
    evt    = v.evt;
    rdSel  = v.rdSel;
    if (!v.pcHold) pc = pc + 32'd4;
    e.name = v.name; e.rd = v.expRd; e.run = v.expRun; e.halt = v.expHalt; e.done = v.expDone;
    sbq.push_back(e);
    tick();
    got = sbq.pop_front();
    chk({got.name, "/rd"}, 64'(rdA), 64'(got.rd));
    chk({got.name, "/running"}, 64'(runA), 64'(got.run));
    chk({got.name, "/halted"}, 64'(haltA), 64'(got.halt));
    chk({got.name, "/done"}, 64'(doneA), 64'(got.done));
  endtask

  task automatic runI(input int n);
    for (int i = 0; i < n; i++) begin
      enable = 1'b0; clear = 1'b0; instr = NOP; stallf = 1'b0;
      flushd = 1'b0; flushe = 1'b0; evt = '0; pc = pc + 32'd4;
      tick();
    end
  endtask

  initial begin
    // Enable edge, then the counted ramp and readouts.
    vecs.push_back(mk("enable", HI, LO, NOP, LO, LO, LO, LO, 4'h0, 4'd0, 32'd0, HI, LO, LO));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk("cycRamp", LO, LO, NOP, LO, LO, LO, LO, 4'h0, 4'd0, 32'(k), HI, LO, LO));
    vecs.push_back(mk("cyc10", LO, LO, NOP, LO, HI, LO, LO, 4'h0, 4'd0, 32'd10, HI, LO, LO));
    vecs.push_back(mk("iss10", LO, LO, NOP, LO, HI, LO, LO, 4'h0, 4'd1, 32'd10, HI, LO, LO));
    vecs.push_back(mk("sq0", LO, LO, NOP, LO, HI, LO, LO, 4'h0, 4'd2, 32'd0, HI, LO, LO));
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk("stallMix", LO, LO, NOP, LO, (k == 0 || k == 4 || k == 8), LO, LO,
                        4'h0, 4'd0, 32'(13 + k), HI, LO, LO));
    vecs.push_back(mk("iss17", LO, LO, NOP, LO, HI, HI, HI, 4'h0, 4'd1, 32'd17, HI, LO, LO));
    vecs.push_back(mk("sqDouble", LO, LO, NOP, LO, HI, LO, LO, 4'h0, 4'd2, 32'd2, HI, LO, LO));
    vecs.push_back(mk("evt0In", LO, LO, NOP, LO, HI, LO, LO, 4'h1, 4'd3, 32'd0, HI, LO, LO));
    vecs.push_back(mk("evt0", LO, LO, NOP, LO, HI, LO, LO, 4'h0, 4'd3, 32'd1, HI, LO, LO));
    vecs.push_back(mk("cyc27", LO, LO, NOP, LO, HI, HI, LO, 4'h0, 4'd0, 32'd27, HI, LO, LO));
    vecs.push_back(mk("sqSingle", LO, LO, NOP, LO, HI, LO, LO, 4'h0, 4'd2, 32'd3, HI, LO, LO));
    vecs.push_back(mk("zeroNoIss", LO, LO, 32'd0, LO, LO, LO, LO, 4'h0, 4'd1, 32'd17, HI, LO, LO));
    vecs.push_back(mk("issHold", LO, LO, NOP, LO, HI, LO, LO, 4'h0, 4'd1, 32'd17, HI, LO, LO));
    // Four idle cycles broken by a PC change, then a full five-cycle window.
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk("idleWin4", LO, LO, 32'd0, HI, LO, LO, LO, 4'h0, 4'd0, 32'(31 + k), HI, LO, LO));
    vecs.push_back(mk("idleBreak", LO, LO, 32'd0, LO, LO, LO, LO, 4'h0, 4'd0, 32'd35, HI, LO, LO));
    for (int k = 0; k < 4; k++)
      vecs.push_back(mk("idleWin5", LO, LO, 32'd0, HI, LO, LO, LO, 4'h0, 4'd0, 32'(36 + k), HI, LO, LO));
    vecs.push_back(mk("haltEdge", LO, LO, 32'd0, HI, LO, LO, LO, 4'h0, 4'd0, 32'd40, LO, HI, HI));
    vecs.push_back(mk("haltHold", LO, LO, 32'd0, HI, LO, LO, LO, 4'h0, 4'd0, 32'd41, LO, HI, LO));
    vecs.push_back(mk("haltEvt", LO, LO, 32'd0, HI, LO, LO, LO, 4'h1, 4'd0, 32'd41, LO, HI, LO));
    vecs.push_back(mk("evtFrozen", LO, LO, 32'd0, HI, LO, LO, LO, 4'h0, 4'd3, 32'd1, LO, HI, LO));
    vecs.push_back(mk("issFrozen", LO, LO, 32'd0, HI, LO, LO, LO, 4'h0, 4'd1, 32'd17, LO, HI, LO));
    vecs.push_back(mk("sel15", LO, LO, 32'd0, HI, LO, LO, LO, 4'h0, 4'd15, 32'd0, LO, HI, LO));
    vecs.push_back(mk("sel7", LO, LO, 32'd0, HI, LO, LO, LO, 4'h0, 4'd7, 32'd0, LO, HI, LO));
    vecs.push_back(mk("enInHalt", HI, LO, 32'd0, HI, LO, LO, LO, 4'h0, 4'd0, 32'd41, LO, HI, LO));
    vecs.push_back(mk("clrHalt", LO, HI, 32'd0, HI, LO, LO, LO, 4'h0, 4'd0, 32'd0, LO, LO, LO));
    // Clear in the same cycle as evt[1] and a flush loses those events.
    vecs.push_back(mk("reEnable", HI, LO, NOP, LO, LO, LO, LO, 4'h0, 4'd0, 32'd0, HI, LO, LO));
    vecs.push_back(mk("evt1a", LO, LO, NOP, LO, LO, LO, LO, 4'h2, 4'd4, 32'd0, HI, LO, LO));
    vecs.push_back(mk("evt1b", LO, LO, NOP, LO, LO, LO, LO, 4'h2, 4'd4, 32'd1, HI, LO, LO));
    vecs.push_back(mk("clrEvt", LO, HI, NOP, LO, LO, HI, LO, 4'h2, 4'd4, 32'd0, LO, LO, LO));
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk("clrRd", LO, LO, NOP, LO, LO, LO, LO, 4'h0, 4'(k), 32'd0, LO, LO, LO));

    reset = 1'b1; enable = 1'b0; clear = 1'b0; instr = 32'd0; pc = 32'd0;
    stallf = 1'b0; flushd = 1'b0; flushe = 1'b0; evt = '0; rdSel = 4'd0;
    tick();
    tick();
    chk("rstRd", 64'(rdA), 64'd0);
    chk("rstRunning", 64'({runA, runW, runS}), 64'd0);
    chk("rstHalted", 64'({haltA, haltW, haltS}), 64'd0);
    chk("rstDone", 64'({doneA, doneW, doneS}), 64'd0);
    chk("rstOvf", 64'({ovfA, ovfW, ovfS}), 64'd0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) runVec(vecs[i]);
    chk("ovfAfterClr", 64'(ovfA), 64'd0);

    // 8-bit wrap and saturate around the 256-cycle boundary.
    enable = 1'b1;
    tick();
    enable = 1'b0;
    rdSel = 4'd0;
    runI(255);
    chk("wrapOvfBefore", 64'(ovfW[0]), 64'd0);
    chk("satOvfBefore", 64'(ovfS[0]), 64'd0);
    runI(1);
    chk("wrapOvfSet", 64'(ovfW[0]), 64'd1);
    chk("satOvfSet", 64'(ovfS[0]), 64'd1);
    runI(1);
    chk("wrap256", 64'(rdW), 64'd0);
    chk("sat256", 64'(rdS), 64'd255);
    chk("wide256", 64'(rdA), 64'd256);
    runI(43);
    runI(1);
    chk("wrap300", 64'(rdW), 64'd44);
    chk("sat300", 64'(rdS), 64'd255);
    chk("wide300", 64'(rdA), 64'd300);
    chk("wrapOvfSticky", 64'(ovfW[0]), 64'd1);
    chk("satOvfSticky", 64'(ovfS[0]), 64'd1);
    chk("wideOvf300", 64'(ovfA), 64'd0);

    // Reset in the middle of a run.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrOvf", 64'({ovfW, ovfS}), 64'd0);
    enable = 1'b1;
    tick();
    enable = 1'b0;
    runI(37);
    runI(1);
    chk("cyc37", 64'(rdA), 64'd37);
    chk("running37", 64'(runA), 64'd1);
    reset = 1'b1;
    runI(1);
    chk("midRstRd", 64'(rdA), 64'd0);
    chk("midRstRunning", 64'({runA, runW, runS}), 64'd0);
    chk("midRstFlags", 64'({haltA, doneA}), 64'd0);
    reset = 1'b0;
    rdSel = 4'd15;
    runI(1);
    chk("sel15Idle", 64'(rdA), 64'd0);
    rdSel = 4'd0;
    runI(1);
    chk("cycAfterRst", 64'(rdA), 64'd0);
    chk("sbEmpty", 64'(sbq.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
